// File: rtl/watch_pkg.sv
// Shared definitions for the watch display path: digit indices, seven-segment
// patterns ({g,f,e,d,c,b,a}, active-high) and a digit-select helper.
package watch_pkg;

  localparam int NUM_DIGITS = 6;

  localparam int D_S1  = 0;
  localparam int D_S10 = 1;
  localparam int D_M1  = 2;
  localparam int D_M10 = 3;
  localparam int D_H1  = 4;
  localparam int D_H10 = 5;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [2:0] idx_t;

  localparam seg_t SEG_0    = 7'b011_1111;
  localparam seg_t SEG_1    = 7'b000_0110;
  localparam seg_t SEG_2    = 7'b101_1011;
  localparam seg_t SEG_3    = 7'b100_1111;
  localparam seg_t SEG_4    = 7'b110_0110;
  localparam seg_t SEG_5    = 7'b110_1101;
  localparam seg_t SEG_6    = 7'b111_1101;
  localparam seg_t SEG_7    = 7'b000_0111;
  localparam seg_t SEG_8    = 7'b111_1111;
  localparam seg_t SEG_9    = 7'b110_1111;
  localparam seg_t SEG_DASH = 7'b100_0000;
  localparam seg_t SEG_OFF  = 7'b000_0000;

  // Pick BCD digit i out of the packed {h10,h1,m10,m1,s10,s1} word.
  function automatic bcd_t digit_at(input logic [4*NUM_DIGITS-1:0] d, input idx_t i);
    return d[4*i +: 4];
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-high seven-segment decoder; non-BCD codes show a dash.
module bcd7seg
  import watch_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    // NOTE: every path assigns seg (default arm included), so no latch is inferred.
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scanner with per-slot anode dead-time.
// Optional digit blinking is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
  import watch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 6_000,
  parameter int DEAD_CYC   = 2,
`ifdef SEG_SCAN_BLINK_EN
  parameter int BLINK_DIV  = 500,
`endif
  parameter int SEG_ACT_LO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYC);
  localparam logic POL = (SEG_ACT_LO != 0);

  logic [PW-1:0]             presc;
  idx_t                      idx;
  logic [4*NUM_DIGITS-1:0]   snap;
  logic                      fresh;    // first slot after reset still needs its snapshot
  logic                      slot_end;
  logic                      capture;

  assign slot_end = (presc == PRESC_MAX);
  assign capture  = fresh || (slot_end && (idx == idx_t'(D_H10)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
      snap  <= '0;
      fresh <= 1'b1;
    end else begin
      fresh <= 1'b0;
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end)
        idx <= (idx == idx_t'(D_H10)) ? '0 : idx + 1'b1;
      if (capture)
        snap <= digits;
    end
  end

  logic blink_hide;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0]         blink_cnt;
  logic                  blink_on;
  logic [NUM_DIGITS-1:0] blink_snap;

  // Phase flips every BLINK_DIV slot ends; the mask is frozen with the digit snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      blink_snap <= '0;
    end else begin
      if (slot_end) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (capture)
        blink_snap <= blink_mask;
    end
  end

  assign blink_hide = !blink_on && blink_snap[idx];
`else
  assign blink_hide = 1'b0;
`endif

  bcd_t cur_bcd;
  seg_t dec_seg;

  assign cur_bcd = digit_at(snap, idx);

  bcd7seg u_bcd7seg (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  seg_t                  seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;

  // Active-high view of the next outputs; polarity is applied at the output register.
  always_comb begin
    seg_n = SEG_OFF;
    dp_n  = 1'b0;
    an_n  = '0;
    if (presc >= DEAD_END) begin
      an_n  = NUM_DIGITS'(1) << idx;
      seg_n = dec_seg;
      dp_n  = dp_mask[idx];
      if ((idx == idx_t'(D_H10)) && blank_lz && (cur_bcd == 4'd0))
        seg_n = SEG_OFF;
      if (blink_hide) begin
        seg_n = SEG_OFF;
        dp_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg         <= {7{POL}};
      dp          <= POL;
      an          <= {NUM_DIGITS{POL}};
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_n ^ {7{POL}};
      dp          <= dp_n ^ POL;
      an          <= an_n ^ {NUM_DIGITS{POL}};
      frame_start <= capture;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV=10, DEAD_CYC=2, active-low outputs.
// Outputs are sampled on the falling edge; cyc counts rising edges since reset release.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] digits;
  logic [5:0]  dp_mask;
  logic        blank_lz;
`ifdef SEG_SCAN_BLINK_EN
  logic [5:0]  blink_mask;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        frame_start;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  logic [6:0] hi_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  seg_scan_driver #(
    .CLK_HZ     (100),
    .SCAN_HZ    (10),
    .DEAD_CYC   (2),
`ifdef SEG_SCAN_BLINK_EN
    .BLINK_DIV  (2),
`endif
    .SEG_ACT_LO (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] lo(input int d);
    return ~hi_tab[d];
  endfunction

  function automatic logic [5:0] an_exp(input int s);
    return ~(6'd1 << s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    rst      = 1'b0;
    digits   = 24'h123456;
    dp_mask  = 6'b000000;
    blank_lz = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = 6'b000000;
`endif
    repeat (2) @(negedge clk);
    check("rst_an", an, 6'h3F);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_start, 1'b0);

    rst = 1'b1;
    cyc = 0;
    tick();
    check("fs_after_rst", frame_start, 1'b1);
    check("dead0_an", an, 6'h3F);
    tick();
    check("fs_low", frame_start, 1'b0);
    check("dead1_an", an, 6'h3F);
    tick();
    check("first_active_an", an, 6'h3E);
    check("first_active_seg", seg, lo(6));

    // Walk all six slots: digit s of 123456 is 6-s.
    for (int s = 0; s < 6; s++) begin
      if (s > 0) begin
        go_to(s * 10 + 1);
        check($sformatf("dead_an_s%0d", s), an, 6'h3F);
      end
      go_to(s * 10 + 5);
      check($sformatf("an_s%0d", s), an, an_exp(s));
      check($sformatf("seg_s%0d", s), seg, lo(6 - s));
      check($sformatf("dp_s%0d", s), dp, 1'b1);
    end
    go_to(59);
    check("fs_pre_wrap", frame_start, 1'b0);
    go_to(60);
    check("fs_wrap", frame_start, 1'b1);

    // Mid-frame digit change must not tear the frame in progress.
    go_to(85);
    digits = 24'h000000;
    go_to(95);
    check("notear_s3", seg, lo(3));
    go_to(115);
    check("notear_s5", seg, lo(1));
    check("notear_an5", an, 6'h1F);
    go_to(119);
    check("fs_period_pre", frame_start, 1'b0);
    go_to(120);
    check("fs_period", frame_start, 1'b1);
    go_to(125);
    check("new_frame_seg", seg, lo(0));

    // Leading-zero blank, invalid BCD dash, decimal points.
    go_to(150);
    digits   = 24'h0F5959;
    blank_lz = 1'b1;
    dp_mask  = 6'b010100;
    go_to(185);
    check("s1_seg", seg, lo(9));
    check("s1_dp", dp, 1'b1);
    go_to(201);
    check("m1_dead_an", an, 6'h3F);
    check("m1_dead_dp", dp, 1'b1);
    go_to(203);
    check("m1_first_an", an, 6'h3B);
    check("m1_first_dp", dp, 1'b0);
    go_to(210);
    check("m1_last_an", an, 6'h3B);
    check("m1_seg", seg, lo(9));
    go_to(211);
    check("m10_dead_an", an, 6'h3F);
    go_to(215);
    check("m10_seg", seg, lo(5));
    check("m10_dp", dp, 1'b1);
    go_to(225);
    check("h1_dash", seg, 7'b0111111);
    check("h1_dp", dp, 1'b0);
    check("h1_an", an, 6'h2F);
    go_to(235);
    check("h10_blank_seg", seg, 7'h7F);
    check("h10_blank_dp", dp, 1'b1);
    check("h10_an", an, 6'h1F);

    // Asynchronous reset in the middle of slot 3.
    go_to(273);
    #2;
    rst      = 1'b0;
    digits   = 24'h987654;
    dp_mask  = 6'b000001;
    blank_lz = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    blink_mask = 6'b000011;
`endif
    #1;
    check("midrst_an", an, 6'h3F);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    go_to(3);
    check("resume_an", an, 6'h3E);
    check("resume_seg", seg, lo(4));
    check("resume_dp", dp, 1'b0);
    go_to(13);
    check("resume_s1_an", an, 6'h3D);
    check("resume_s1_seg", seg, lo(5));
    go_to(25);
    check("unmasked_s2_seg", seg, lo(6));

`ifdef SEG_SCAN_BLINK_EN
    go_to(65);
    check("blink_off_s0_seg", seg, 7'h7F);
    check("blink_off_s0_dp", dp, 1'b1);
    check("blink_off_s0_an", an, 6'h3E);
    go_to(75);
    check("blink_off_s1_seg", seg, 7'h7F);
    go_to(85);
    check("blink_on_s2_seg", seg, lo(6));
`else
    go_to(65);
    check("steady_s0_seg", seg, lo(4));
    check("steady_s0_dp", dp, 1'b0);
    go_to(75);
    check("steady_s1_seg", seg, lo(5));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
